// File: rtl/gpr_pkg.sv
// Shared types and constants for the general-purpose register slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gpr_pkg;

    localparam int DATA_W = 24;

    typedef logic [DATA_W-1:0] word_t;

    localparam word_t WORD_ZERO = '0;

    // Even parity of a full data word, as stored beside the register.
    function automatic logic word_parity(input word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/gpr_cell.sv
// Async-reset, enable-loaded flop bank; optional stored parity (GPR1_PARITY_EN).
// Latency: 1 cycle from an enabled edge to q; reset acts immediately.
// Backpressure: none; every enabled edge is accepted.
module gpr_cell
    import gpr_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
`ifdef GPR1_PARITY_EN
    output logic             parity_err,
`endif
    output logic [WIDTH-1:0] q
);

    // Data storage: reset wins, otherwise load d when enabled, else hold.
    // Gating on en keeps an undriven d from ever reaching q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

`ifdef GPR1_PARITY_EN
    logic par_q;

    // Parity captured from the incoming word alongside every load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= ^RESET_VAL;
        end else if (en) begin
            par_q <= ^d;
        end
    end

    // Diagnostic only: flags a stored word whose parity no longer matches.
    always_comb begin
        parity_err = (^q) != par_q;
    end
`endif

endmodule

// File: rtl/gpr1.sv
// 24-bit datapath register: MUX always shows contents, BUS_OUT gated to zero unless read_bus (GPR1_PARITY_EN adds parity_err).
// Latency: 1 cycle write-to-output; bus gating and reset are combinational/immediate.
// Backpressure: none; writes and bus reads are accepted every cycle.
module gpr1
    import gpr_pkg::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic             read_bus,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] MUX,
`ifdef GPR1_PARITY_EN
    output logic             parity_err,
`endif
    output logic [WIDTH-1:0] BUS_OUT
);

    logic [WIDTH-1:0] q;

    gpr_cell #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_cell (
        .clk        (clk),
        .rst        (rst),
        .en         (write),
        .d          (data_in),
`ifdef GPR1_PARITY_EN
        .parity_err (parity_err),
`endif
        .q          (q)
    );

    assign MUX = q;

    // Bus drive is zero when not selected so the arbiter can OR all registers.
    always_comb begin
        BUS_OUT = read_bus ? q : '0;
    end

endmodule

// File: tb/tb_gpr1.sv
// Directed bench for gpr1: an expected-contents model checked every cycle, plus literal checks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_gpr1;
    import gpr_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  write;
    logic  read_bus;
    word_t data_in;
    word_t MUX;
    word_t BUS_OUT;
`ifdef GPR1_PARITY_EN
    logic  parity_err;
`endif

    int    tests = 0;
    int    fails = 0;
    word_t exp_q = WORD_ZERO;
    bit    chk_en = 1'b0;

    gpr1 dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .read_bus   (read_bus),
        .data_in    (data_in),
        .MUX        (MUX),
`ifdef GPR1_PARITY_EN
        .parity_err (parity_err),
`endif
        .BUS_OUT    (BUS_OUT)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%06h, expected 0x%06h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic w, input logic rb, input word_t d);
        write    = w;
        read_bus = rb;
        data_in  = d;
    endtask

    // Advance one rising edge; the register takes data_in when write is set and reset is low.
    task automatic tick();
        @(posedge clk);
        if (!rst && write) exp_q = data_in;
        #3;
    endtask

    // Per-cycle compare against the expected register contents.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mux_model", MUX, exp_q);
            check("bus_model", BUS_OUT, read_bus ? exp_q : WORD_ZERO);
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 24'h000000);
        #25;
        check("reset_mux", MUX, 24'h000000);
        check("reset_bus", BUS_OUT, 24'h000000);
        @(posedge clk);
        #3;
        rst    = 1'b0;
        exp_q  = WORD_ZERO;
        chk_en = 1'b1;

        // Load 100 for ~50 ns with bus disabled.
        drive(1'b1, 1'b0, 24'd100);
        tick();
        tick();
        #6;
        check("load_mux", MUX, 24'd100);
        check("load_bus_gated", BUS_OUT, 24'd0);

        // Stop writing, enable bus.
        drive(1'b0, 1'b1, 24'd100);
        #1;
        check("read_bus", BUS_OUT, 24'd100);
        check("read_mux", MUX, 24'd100);
        tick();

        // Hold while data_in changes.
        drive(1'b0, 1'b1, 24'hFFFFFF);
        tick();
        tick();
        tick();
        check("hold_mux", MUX, 24'd100);

        // Undriven data_in with write low must not disturb contents.
        data_in = 'x;
        tick();
        check("x_hold_mux", MUX, 24'd100);

        // Simultaneous write and bus read: old value before the edge, new after.
        drive(1'b1, 1'b1, 24'd5);
        tick();
        drive(1'b1, 1'b1, 24'd9);
        #1;
        check("simul_before", BUS_OUT, 24'd5);
        tick();
        check("simul_after", BUS_OUT, 24'd9);

        // Boundary values and same-cycle bus drop.
        drive(1'b1, 1'b1, 24'hFFFFFF);
        tick();
        check("all_ones_mux", MUX, 24'hFFFFFF);
        check("all_ones_bus", BUS_OUT, 24'hFFFFFF);
        read_bus = 1'b0;
        #1;
        check("bus_drop", BUS_OUT, 24'h000000);
        check("bus_drop_mux", MUX, 24'hFFFFFF);
        drive(1'b1, 1'b1, 24'h000000);
        tick();
        check("all_zero_mux", MUX, 24'h000000);
        drive(1'b1, 1'b0, 24'hA5A5A5);
        tick();
        check("pattern_mux", MUX, 24'hA5A5A5);

        // Mid-cycle asynchronous reset with contents 0x000064.
        drive(1'b1, 1'b1, 24'h000064);
        tick();
        drive(1'b0, 1'b1, 24'h000064);
        check("pre_reset_bus", BUS_OUT, 24'h000064);
        #5;
        rst   = 1'b1;
        exp_q = WORD_ZERO;
        #1;
        check("async_reset_mux", MUX, 24'h000000);
        check("async_reset_bus", BUS_OUT, 24'h000000);
        // Reset dominates write across an edge.
        drive(1'b1, 1'b1, 24'h000123);
        tick();
        check("reset_dominates", MUX, 24'h000000);
        rst = 1'b0;
        tick();
        check("post_reset_load", MUX, 24'h000123);

`ifdef GPR1_PARITY_EN
        drive(1'b1, 1'b0, 24'h000007);
        tick();
        drive(1'b0, 1'b0, 24'h000000);
        tick();
        check("parity_clean", {23'd0, parity_err}, 24'd0);
        chk_en = 1'b0;
        force dut.u_cell.q = 24'h000006;
        #1;
        check("parity_flip", {23'd0, parity_err}, 24'd1);
        release dut.u_cell.q;
        #1;
`endif

        chk_en = 1'b0;
        #20;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpr1.md
Name: gpr1

Overview:
- 24-bit general-purpose register in the processor datapath.
- Loads from `data_in` on a clock edge when `write` is high.
- Permanently presents its contents to the ALU/operand multiplexer via `MUX`.
- Drives the shared data bus via `BUS_OUT` only when `read_bus` is asserted; otherwise `BUS_OUT` is held at zero, so the bus is OR-combinable.

Parameters:
- WIDTH, 24, data width of the register and of all data ports.
- RESET_VAL, 0, value loaded by reset, WIDTH bits.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; asynchronous, active-high.
- write  input  1  load enable; register captures `data_in` at the rising clock edge.
- read_bus  input  1  bus drive enable.
- data_in  input  WIDTH  value to load.
- MUX  output  WIDTH  register contents, always driven.
- BUS_OUT  output  WIDTH  register contents when `read_bus`=1, else all zeros.
- parity_err  output  1  present only with GPR1_PARITY_EN (see Optional Feature).

Behaviour:
- Storage: one WIDTH-bit register `q`.
- Reset:
  - `rst`=1 forces `q`=RESET_VAL immediately, regardless of clk.
  - While `rst` is high, `MUX`=RESET_VAL and `BUS_OUT`=RESET_VAL if `read_bus`=1, else 0.
  - Reset dominates `write`.
  - Deassertion is synchronised by the system; no internal synchroniser.
- Write:
  - At rising clk with `rst`=0 and `write`=1: `q` <= `data_in`.
  - With `write`=0: `q` holds.
  - Latency 1 cycle: the new value appears on `MUX` right after the capturing edge.
- No write-through bypass: the value written at an edge never appears on the outputs before that edge.
- `MUX`: combinational copy of `q`; no gating.
- `BUS_OUT`:
  - Combinational: `read_bus` ? `q` : 0.
  - No tri-state; the bus arbiter ORs all register outputs.
- Simultaneous `write`=1 and `read_bus`=1:
  - `BUS_OUT` shows the old `q` until the edge, then the new `q`.
  - Legal, no error.
- `data_in` is ignored when `write`=0; X on `data_in` with `write`=0 must not propagate.
- Widths are exact; no truncation or extension anywhere.

Optional Feature:
- Macro: GPR1_PARITY_EN.
- Defined:
  - A parity bit (XOR of `data_in`) is stored alongside `q` on every write; reset clears it to the parity of RESET_VAL.
  - Output `parity_err` = XOR(`q`) != stored parity, combinational.
  - Purely diagnostic; never alters `MUX`/`BUS_OUT`.
- Undefined: no parity storage and no `parity_err` port; behaviour otherwise identical.

Decomposition:
- Shared package `gpr_pkg`:
  - constant DATA_W = 24.
  - typedef `word_t` (logic [DATA_W-1:0]).
  - constant WORD_ZERO.
- Sub-module `gpr_cell`:
  - Parameterised async-reset enable flop bank with optional parity.
  - Instantiated once by gpr1.
  - gpr1 adds the output gating.

Test Plan:
- Reset: assert `rst` mid-cycle with `q`=0x000064 -> `MUX`=0 immediately, before the next clk edge; `BUS_OUT`=0 with `read_bus`=1.
- Load then read:
  - `write`=1, `read_bus`=0, `data_in`=100 for 50 ns (20 ns clock) -> `MUX`=100, `BUS_OUT`=0.
  - Then `write`=0, `read_bus`=1, `data_in`=100 -> `BUS_OUT`=100, `MUX`=100.
- Hold: `write`=0, `data_in` changed to 0xFFFFFF over 3 cycles -> `MUX` stays 100.
- Simultaneous: `q`=5, `read_bus`=1, `write`=1, `data_in`=9 -> `BUS_OUT`=5 before the edge, 9 after it.
- Boundary values: write 0xFFFFFF then 0x000000 -> `MUX` tracks exactly; `BUS_OUT` gates to 0 when `read_bus` drops within the same cycle.
- Parity (GPR1_PARITY_EN): write 0x000007 -> `parity_err`=0; force-flip bit 0 of `q` -> `parity_err`=1.
